pwm_multi_channel: RTL
======================

# pwm_multi_channel

Parametrised multi-channel PWM generator for the motor-drive path. It runs on the 50 MHz system clock and has an internal prescaler, a runtime-programmable period and a per-channel duty. Period and duty updates are double-buffered so they only take effect at a period boundary. It drives the forward/back H-bridge inputs and any further PWM loads, with a common counter and therefore phase-aligned edges across channels.

## Interface
Parameters:
- NUM_CH, 2, number of PWM output channels (≥1)
- CNT_W, 11, width of period/duty/counter values
- PRESCALE, 50, clk_50MHz cycles per PWM tick (≥1; 50 → 1 MHz tick)
- RESET_PERIOD, 500, active period loaded at reset (ticks)

Ports:
- clk_50MHz  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = run; 0 = hold prescaler/counter at 0 and force outputs low
- period  in  CNT_W  requested period in ticks (pending value)
- duty  in  NUM_CH*CNT_W  requested duty per channel; channel i at [i*CNT_W +: CNT_W]
- load  in  1  single-cycle strobe: capture period/duty into shadow registers
- pwm_out  out  NUM_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse on the cycle the counter wraps to 0
- update_done  out  1  one-cycle pulse when a shadow set becomes active

## Operation
- Prescaler counts 0..PRESCALE-1 while enable=1; tick asserted internally on the cycle count = PRESCALE-1, then the prescaler wraps to 0.
- Edge-aligned mode (default): period counter cnt advances on each tick through 0..P_act-1, then wraps to 0. P_act = 0 is treated as 1, so cnt stays at 0.
- Channel i: pwm_out[i] ← enable & (cnt_next < D_act[i]), registered. D_act = 0 → constant low; D_act ≥ P_act → constant high.
- Shadow load: load=1 captures period and all duties into shadow regs and sets pending.
- A second load before the boundary overwrites the shadow; only the last one is applied.
- At a wrap tick with pending=1: P_act/D_act ← shadow, pending ← 0, update_done=1 on that same cycle.
- load coinciding with a wrap tick: the new values are captured and applied at the following wrap, not the current one.
- enable 1→0: counters clear to 0 and pwm_out goes low next cycle. pending is retained.
- enable 0→1: counting restarts from prescaler 0 and cnt 0. The first period_start pulse occurs at the first wrap.
- rst mid-operation: everything returns to its reset values immediately, including shadow and pending.
- Reset values: pwm_out=0, period_start=0, update_done=0, prescaler=0, cnt=0, P_act=RESET_PERIOD, D_act[*]=0, shadow=0, pending=0.

## Timing
- pwm_out changes only on the clk_50MHz edge that follows a tick cycle. Outputs are glitch-free, registered and never combinational.
- Edge-aligned output period = P_act×PRESCALE clocks. High time = min(D_act, P_act)×PRESCALE clocks.
- period_start and update_done assert on the same cycle and are each one clock wide.
- Latency from the load strobe to the new duty appearing on pwm_out is ≤ (P_act+1)×PRESCALE clocks.
- Counter arithmetic is unsigned CNT_W bits. Comparisons are unsigned, and cnt never exceeds P_act-1 in edge-aligned mode.

## Configuration
- PWM_CENTER_ALIGNED_EN defined:
  - cnt counts up 0..P_act, then down P_act-1..1, then wraps to 0, so one PWM period = 2·P_act ticks.
  - pwm_out[i] = cnt < D_act[i], giving symmetric pulses centred on cnt=0.
  - Wrap, period_start and shadow apply all happen at the return to 0.
  - D_act > P_act → constant high.
- PWM_CENTER_ALIGNED_EN undefined: edge-aligned only, with no direction register synthesised.

## Structure
- Shared package pwm_pkg holds:
  - CNT_W default
  - PRESCALE_1MHZ = 50
  - RESET_PERIOD default
  - the counter-direction enum typedef (UP, DOWN), used only under the macro
- One natural sub-module: pwm_prescaler (PRESCALE parameter, enable, rst; outputs tick), reusable by other timer blocks.
- Per-channel comparators are generated in a loop inside pwm_multi_channel.

## Test plan
- Reset then enable, PRESCALE=50, defaults → pwm_out=0 throughout (D_act=0); period_start every 25 000 clocks; update_done never asserts.
- load period=500, duty={305,315} → update_done at the first wrap. Next period: ch1 high 15 750 clocks, ch0 high 15 250, both with period 25 000 clocks, rising edges aligned.
- Boundary duties, period=10: duty 0 → ch constant 0; duty 10 and duty 2047 → constant 1; period=0 → counter stuck at 0, output high iff duty≥1.
- Double load: values A then B within one period → only B applied at wrap, one update_done. Load on the exact wrap-tick cycle → applied one period later.
- enable dropped mid-period → pwm_out=0 next cycle. Re-enable → first period_start after exactly P_act×PRESCALE clocks. Assert rst mid-pulse → outputs 0 asynchronously, P_act back to 500.
- With PWM_CENTER_ALIGNED_EN, period=4, duty=2, PRESCALE=1 → cnt sequence 0,1,2,3,4,3,2,1,0 and pwm_out high on cnt∈{0,1}: 3 ticks high of 8, centred on the wrap.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator and other timer blocks.
package pwm_pkg;

  localparam int CNT_W_DEFAULT        = 11;
  localparam int PRESCALE_1MHZ        = 50;
  localparam int RESET_PERIOD_DEFAULT = 500;

  // Counter direction, only meaningful for the center-aligned build.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: one-cycle tick every PRESCALE clocks while enabled.
module pwm_prescaler #(
  parameter int PRESCALE = pwm_pkg::PRESCALE_1MHZ
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int              PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shared counter and double-buffered period/duty.
// Define PWM_CENTER_ALIGNED_EN for up/down (center-aligned) counting; default is edge-aligned.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int PRESCALE     = PRESCALE_1MHZ,
  parameter int RESET_PERIOD = RESET_PERIOD_DEFAULT
) (
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    update_done
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic                         tick;
  cnt_t                         cnt, cnt_next, p_act, p_shadow, p_eff;
  logic [NUM_CH-1:0][CNT_W-1:0] d_act, d_shadow, d_next;
  logic [NUM_CH-1:0]            pwm_next;
  logic                         pending, wrap, apply;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .enable    (enable),
    .tick      (tick)
  );

  // A zero period behaves as a one-tick period so the counter parks at 0.
  assign p_eff = (p_act == '0) ? cnt_t'(1) : p_act;
  assign apply = wrap & pending;

`ifdef PWM_CENTER_ALIGNED_EN
  cnt_dir_e dir, dir_next;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wrap     = 1'b0;
    cnt_next = cnt;
    dir_next = dir;
    if (!enable) begin
      cnt_next = '0;
      dir_next = UP;
    end else if (tick) begin
      if (dir == UP) begin
        if (cnt < p_eff) begin
          cnt_next = cnt + 1'b1;
        end else if (p_eff == cnt_t'(1)) begin
          wrap     = 1'b1;
          cnt_next = '0;
        end else begin
          dir_next = DOWN;
          cnt_next = cnt - 1'b1;
        end
      end else if (cnt <= cnt_t'(1)) begin
        wrap     = 1'b1;
        cnt_next = '0;
        dir_next = UP;
      end else begin
        cnt_next = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      dir <= UP;
    end else begin
      dir <= dir_next;
    end
  end
`else
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wrap     = 1'b0;
    cnt_next = cnt;
    if (!enable) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt == p_eff - 1'b1) begin
        wrap     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end
`endif

  // The new duty governs the period that starts at the applying wrap.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign d_next[i]   = apply ? d_shadow[i] : d_act[i];
    assign pwm_next[i] = enable & (cnt_next < d_next[i]);
  end

  // NOTE: shadow and active duty sets are plain flops, so all of them are reset, not just control.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      p_act        <= cnt_t'(RESET_PERIOD);
      d_act        <= '0;
      p_shadow     <= '0;
      d_shadow     <= '0;
      pending      <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      update_done  <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      pwm_out      <= pwm_next;
      period_start <= wrap;
      update_done  <= apply;
      // A load on the wrap tick re-arms pending, deferring its values one period.
      pending      <= load | (pending & ~wrap);
      if (apply) begin
        p_act <= p_shadow;
        d_act <= d_shadow;
      end
      if (load) begin
        p_shadow <= period;
        d_shadow <= duty;
      end
    end
  end

endmodule
